store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/brisc_pkg.sv | 22 ++
 rtl/stb_fwd_match.sv | 68 ++++++
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared core types: data sizes, store-buffer entry layout and default depth.
package brisc_pkg;
  localparam int XLEN            = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int STB_NUM_ENTRIES = 4;

  typedef enum logic {
    SIZE_B = 1'b0,
    SIZE_W = 1'b1
  } data_size_e;

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [XLEN-1:0]          data;
    data_size_e               size;
  } stb_entry_t;

  function automatic logic [7:0] sel_byte(input logic [XLEN-1:0] w, input logic [1:0] off);
    return w[8*off +: 8];
  endfunction
endpackage

// File: rtl/stb_fwd_match.sv
// Store-to-load forwarding lookup: youngest valid match wins.
// STB_FORWARD_EN enables data forwarding; otherwise any word match stalls.
module stb_fwd_match
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
  parameter int ADDR_W      = ADDRESS_WIDTH
)(
  input  stb_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [$clog2(NUM_ENTRIES)-1:0] head,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  data_size_e        ld_size,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data,
  output logic              ld_stall
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]           hit_v, stall_v;
  logic [NUM_ENTRIES-1:0][XLEN-1:0] data_v;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    logic word_m;
    assign word_m = entries[i].valid && (entries[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
`ifdef STB_FORWARD_EN
    logic byte_m;
    assign byte_m = word_m && (entries[i].addr[1:0] == ld_addr[1:0]);
    // A byte store only partially covers a word load, so that case must stall.
    assign hit_v[i]   = (entries[i].size == SIZE_W) ? word_m : ((ld_size == SIZE_B) && byte_m);
    assign stall_v[i] = (entries[i].size == SIZE_B) && (ld_size == SIZE_W) && word_m;
    assign data_v[i]  = (entries[i].size == SIZE_B) ? XLEN'(entries[i].data[7:0]) :
                        (ld_size == SIZE_W)         ? entries[i].data :
                                                      XLEN'(sel_byte(entries[i].data, ld_addr[1:0]));
`else
    assign hit_v[i]   = 1'b0;
    assign stall_v[i] = word_m;
    assign data_v[i]  = '0;
`endif
  end

`ifndef STB_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ld_size, ld_addr[1:0], entries};
`endif

  // Walk oldest to youngest from head; the last match seen is the youngest.
  logic [IDX_W-1:0] idx;
  always_comb begin
    fwd_hit  = 1'b0;
    ld_stall = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idx = head + IDX_W'(i);
      if (hit_v[idx] || stall_v[idx]) begin
        fwd_hit  = hit_v[idx];
        ld_stall = stall_v[idx];
        fwd_data = hit_v[idx] ? data_v[idx] : '0;
      end
    end
    if (!ld_req) begin
      fwd_hit  = 1'b0;
      ld_stall = 1'b0;
      fwd_data = '0;
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining to the data cache, with load lookup.
// Optional macro STB_FORWARD_EN turns on store-to-load data forwarding.
module store_buffer
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
  parameter int ADDR_W      = ADDRESS_WIDTH
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [XLEN-1:0]   push_data,
  input  data_size_e        push_size,
  output logic              full,
  output logic              empty,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  data_size_e        ld_size,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data,
  output logic              ld_stall,
  output logic              cache_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]   write_data,
  output data_size_e        data_size,
  input  logic              cache_miss,
  input  logic              fill,
  input  logic              flush,
  output logic              flush_done
);
  localparam int PW = $clog2(NUM_ENTRIES);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_MISS_WAIT = 2'd2;

  logic [PW:0]                   head_q, head_d, tail_q, tail_d;
  stb_entry_t [NUM_ENTRIES-1:0]  mem_q, mem_d;
  logic [1:0]                    state_q, state_d;
  logic                          flush_pend_q, flush_pend_d;

  logic ptr_empty, ptr_full, push_ok, pop;

  assign ptr_empty = (head_q == tail_q);
  assign ptr_full  = (head_q[PW-1:0] == tail_q[PW-1:0]) && (head_q[PW] != tail_q[PW]);

  assign empty      = ptr_empty;
  assign full       = ptr_full | flush | flush_pend_q;
  assign flush_done = flush_pend_q & ptr_empty;

  assign push_ok     = push & ~full;
  assign cache_write = (state_q == S_WRITE) & ~ld_req & ~ptr_empty;
  assign pop         = cache_write & ~cache_miss;

  assign write_addr = mem_q[head_q[PW-1:0]].addr[ADDR_W-1:0];
  assign write_data = mem_q[head_q[PW-1:0]].data;
  assign data_size  = mem_q[head_q[PW-1:0]].size;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      mem_d[head_q[PW-1:0]].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (push_ok) begin
      mem_d[tail_q[PW-1:0]] = '{valid: 1'b1, addr: ADDRESS_WIDTH'(push_addr),
                                data: push_data, size: push_size};
      tail_d = tail_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!ptr_empty && !ld_req) state_d = S_WRITE;
      S_WRITE: begin
        if (ptr_empty)       state_d = S_IDLE;
        else if (ld_req)     state_d = S_WRITE;
        else if (cache_miss) state_d = S_MISS_WAIT;
        else if (head_d == tail_d) state_d = S_IDLE;
      end
      S_MISS_WAIT: if (fill) state_d = S_WRITE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Flush request is remembered until the buffer drains; done pulses once.
  always_comb begin
    flush_pend_d = flush_pend_q ? ~ptr_empty : flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      mem_q        <= '0;
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      mem_q        <= mem_d;
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  stb_fwd_match #(.NUM_ENTRIES(NUM_ENTRIES), .ADDR_W(ADDR_W)) u_fwd (
    .entries  (mem_q),
    .head     (head_q[PW-1:0]),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_size  (ld_size),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .ld_stall (ld_stall)
  );
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer: drain order, miss/fill retry, lookup, flush, reset.
module tb_store_buffer;
  import brisc_pkg::*;

`ifdef STB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [31:0]       push_addr;
  logic [31:0]       push_data;
  data_size_e        push_size;
  logic              full, empty;
  logic              ld_req;
  logic [31:0]       ld_addr;
  data_size_e        ld_size;
  logic              fwd_hit, ld_stall;
  logic [31:0]       fwd_data;
  logic              cache_write;
  logic [31:0]       write_addr, write_data;
  data_size_e        data_size;
  logic              cache_miss, fill, flush, flush_done;

  store_buffer #(.NUM_ENTRIES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .push_data(push_data),
    .push_size(push_size), .full(full), .empty(empty), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_size(ld_size), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
    .cache_write(cache_write), .write_addr(write_addr), .write_data(write_data),
    .data_size(data_size), .cache_miss(cache_miss), .fill(fill), .flush(flush),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [64:0] expq[$];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every completed (non-missed) cache write must match the oldest expected store.
  always @(negedge clk) begin
    if (!reset && cache_write && !cache_miss) begin
      if (expq.size() == 0) chk("wr_unexpected", 72'(expq.size()), 72'd1);
      else begin
        logic [64:0] e;
        e = expq.pop_front();
        chk("wr_order", {write_addr, write_data, data_size}, 72'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input data_size_e s, input bit track);
    push = 1'b1; push_addr = a; push_data = d; push_size = s;
    if (track) expq.push_back({a, d, s});
    step();
    push = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    @(negedge clk);
    while (!empty && k < 60) begin @(negedge clk); k++; end
    chk(tag, 72'(empty), 72'd1);
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input data_size_e s,
                       input logic eh, input logic es, input logic [31:0] ed);
    ld_addr = a; ld_size = s;
    @(negedge clk);
    chk({tag, "_hit"}, 72'(fwd_hit), 72'(eh));
    chk({tag, "_stall"}, 72'(ld_stall), 72'(es));
    chk({tag, "_data"}, 72'(fwd_data), 72'(ed));
    step();
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_addr = '0; push_data = '0; push_size = SIZE_W;
    ld_req = 1'b0; ld_addr = '0; ld_size = SIZE_W; cache_miss = 1'b0; fill = 1'b0; flush = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_empty", 72'(empty), 72'd1);
    chk("rst_full", 72'(full), 72'd0);
    chk("rst_cw", 72'(cache_write), 72'd0);
    chk("rst_fwd", 72'({fwd_hit, ld_stall, flush_done}), 72'd0);
    chk("rst_wdata", 72'({write_addr, write_data, fwd_data}), 72'd0);
    step();
    reset = 1'b0;
    step();

    // Single store latency: cache_write two edges after the push edge
    do_push(32'h100, 32'hDEADBEEF, SIZE_W, 1'b1);
    @(negedge clk);
    chk("lat_n1_cw", 72'(cache_write), 72'd0);
    chk("lat_n1_empty", 72'(empty), 72'd0);
    step();
    @(negedge clk);
    chk("lat_n2_cw", 72'(cache_write), 72'd1);
    chk("lat_n2_addr", 72'(write_addr), 72'h100);
    step();
    @(negedge clk);
    chk("lat_n3_empty", 72'(empty), 72'd1);
    chk("lat_n3_cw", 72'(cache_write), 72'd0);
    step();

    // Fill to full; drop the fifth push; order preserved on drain
    ld_req = 1'b1; ld_addr = 32'hF00; ld_size = SIZE_W;
    for (int i = 0; i < 4; i++) do_push(32'h400 + 32'(4*i), 32'hA0 + 32'(i), SIZE_W, 1'b1);
    @(negedge clk);
    chk("fill_full", 72'(full), 72'd1);
    step();
    do_push(32'h500, 32'h55555555, SIZE_W, 1'b0);
    @(negedge clk);
    chk("drop_full", 72'(full), 72'd1);
    step();
    ld_req = 1'b0;
    step(); step();
    @(negedge clk);
    chk("pop_notfull", 72'(full), 72'd0);
    wait_empty("fill_drain");
    chk("fill_q", 72'(expq.size()), 72'd0);
    step();

    // Miss then fill: retry same entry
    cache_miss = 1'b1;
    do_push(32'h600, 32'h0000600D, SIZE_W, 1'b1);
    step();
    @(negedge clk);
    chk("miss_try_cw", 72'(cache_write), 72'd1);
    step();
    @(negedge clk);
    chk("miss_wait_cw", 72'(cache_write), 72'd0);
    step();
    @(negedge clk);
    chk("miss_hold_cw", 72'(cache_write), 72'd0);
    chk("miss_hold_empty", 72'(empty), 72'd0);
    step();
    cache_miss = 1'b0; fill = 1'b1;
    step();
    fill = 1'b0;
    @(negedge clk);
    chk("retry_cw", 72'(cache_write), 72'd1);
    chk("retry_addr", 72'(write_addr), 72'h600);
    step();
    @(negedge clk);
    chk("retry_empty", 72'(empty), 72'd1);
    step();

    // Lookup: two word stores to the same word, youngest wins
    ld_req = 1'b1; ld_addr = 32'hF00; ld_size = SIZE_W;
    do_push(32'h200, 32'h11223344, SIZE_W, 1'b1);
    do_push(32'h200, 32'hAABBCCDD, SIZE_W, 1'b1);
    probe("b201", 32'h201, SIZE_B, FWD, !FWD, FWD ? 32'h000000CC : 32'h0);
    probe("b203", 32'h203, SIZE_B, FWD, !FWD, FWD ? 32'h000000AA : 32'h0);
    probe("w200", 32'h200, SIZE_W, FWD, !FWD, FWD ? 32'hAABBCCDD : 32'h0);
    probe("w204", 32'h204, SIZE_W, 1'b0, 1'b0, 32'h0);
    ld_req = 1'b0;
    #1;
    chk("noreq_hit", 72'({fwd_hit, ld_stall}), 72'd0);
    wait_empty("fwd_drain");
    step();

    // Byte store against word / byte loads
    ld_req = 1'b1; ld_addr = 32'hF00; ld_size = SIZE_W;
    do_push(32'h302, 32'h12345655, SIZE_B, 1'b1);
    probe("w300", 32'h300, SIZE_W, 1'b0, 1'b1, 32'h0);
    probe("b302", 32'h302, SIZE_B, FWD, !FWD, FWD ? 32'h00000055 : 32'h0);
    probe("b301", 32'h301, SIZE_B, 1'b0, !FWD, 32'h0);
    do_push(32'h300, 32'h99887766, SIZE_W, 1'b1);
    probe("w300y", 32'h300, SIZE_W, FWD, !FWD, FWD ? 32'h99887766 : 32'h0);
    probe("b302y", 32'h302, SIZE_B, FWD, !FWD, FWD ? 32'h00000088 : 32'h0);
    ld_req = 1'b0;
    wait_empty("byte_drain");
    step();

    // Flush on an empty buffer
    flush = 1'b1;
    @(negedge clk);
    chk("fe_full", 72'(full), 72'd1);
    chk("fe_done0", 72'(flush_done), 72'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fe_done1", 72'(flush_done), 72'd1);
    step();
    @(negedge clk);
    chk("fe_done2", 72'(flush_done), 72'd0);
    chk("fe_full2", 72'(full), 72'd0);
    step();

    // Flush with pending entries: pushes blocked, done on first empty cycle
    ld_req = 1'b1; ld_addr = 32'hF00;
    do_push(32'h700, 32'h70, SIZE_W, 1'b1);
    do_push(32'h704, 32'h74, SIZE_W, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fp_full", 72'(full), 72'd1);
    step();
    do_push(32'h708, 32'h78, SIZE_W, 1'b0);
    ld_req = 1'b0;
    wait_empty("fp_drain");
    chk("fp_done", 72'(flush_done), 72'd1);
    chk("fp_q", 72'(expq.size()), 72'd0);
    step();
    @(negedge clk);
    chk("fp_done_off", 72'(flush_done), 72'd0);
    step();

    // Reset during MISS_WAIT discards everything
    ld_req = 1'b1; ld_addr = 32'hF00;
    for (int i = 0; i < 3; i++) do_push(32'h800 + 32'(4*i), 32'h80 + 32'(i), SIZE_W, 1'b0);
    flush = 1'b1; cache_miss = 1'b1;
    step();
    flush = 1'b0; ld_req = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("mw_cw", 72'(cache_write), 72'd0);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mwr_empty", 72'(empty), 72'd1);
    chk("mwr_cw", 72'(cache_write), 72'd0);
    chk("mwr_done", 72'(flush_done), 72'd0);
    step();
    reset = 1'b0; cache_miss = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst", 72'({cache_write, flush_done, empty}), 72'd1);
      step();
    end
    chk("final_q", 72'(expq.size()), 72'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
